// File: rtl/seq_divider.sv
// seq_divider: multicycle signed integer divider (restoring shift-subtract,
// one quotient bit per cycle). Also contains cl_adder, the carry-lookahead
// adder that performs the trial subtraction in each iteration.

module cl_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow
);

  // 4-bit lookahead groups; each carry inside a group is formed directly
  // from the group carry-in and the accumulated generate/propagate terms.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic             cg;
    logic             gacc;
    logic             pacc;
    logic             c;
    g  = a & b;
    p  = a ^ b;
    s  = '0;
    cg = cin;
    for (int k = 0; k < WIDTH / 4; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 0; j < 4; j++) begin
        int i;
        i    = 4 * k + j;
        c    = gacc | (pacc & cg);
        s[i] = p[i] ^ c;
        gacc = g[i] | (p[i] & gacc);
        pacc = pacc & p[i];
      end
      cg = gacc | (pacc & cg);
    end
    return {cg, s};
  endfunction

  // Sum, carry-out and signed overflow of data_A + data_B + Cin.
  always_comb begin
    {Cout, sum} = cla_add(data_A, data_B, Cin);
    overflow    = (data_A[WIDTH-1] == data_B[WIDTH-1]) &&
                  (sum[WIDTH-1] != data_A[WIDTH-1]);
  end

endmodule

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         count;

  logic signed [WIDTH-1:0]  a_lat;
  logic signed [WIDTH-1:0]  b_lat;
  logic                     sign_a;
  logic                     sign_b;
  logic [WIDTH-1:0]         q_reg;
  logic [WIDTH-1:0]         d_reg;
  logic [WIDTH:0]           r_reg;

  logic                     accept;
  logic                     b_zero;
  logic                     ovf_case;
  logic [WIDTH+1:0]         rq_sh;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;
  logic                     unused_ovf;
  logic                     trial_ok;
  logic [WIDTH:0]           r_trial;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? -x : x;
  endfunction

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign b_zero   = (b_lat == '0);
  assign ovf_case = (a_lat == {1'b1, {(WIDTH-1){1'b0}}}) && (b_lat == '1);

  // Shift {R,Q} left by one; trial subtraction R - D = R + ~D + 1.
  assign rq_sh = {r_reg, q_reg[WIDTH-1]};

  cl_adder #(.WIDTH(WIDTH)) u_add (
    .data_A   (rq_sh[WIDTH-1:0]),
    .data_B   (~d_reg),
    .Cin      (1'b1),
    .sum      (add_sum),
    .Cout     (add_cout),
    .overflow (unused_ovf)
  );

  // Carry out of the low word means no borrow; any set upper bit of the
  // shifted remainder also guarantees the difference is non-negative.
  assign trial_ok = rq_sh[WIDTH+1] | rq_sh[WIDTH] | add_cout;
  assign r_trial  = {~(rq_sh[WIDTH] ^ add_cout), add_sum};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = b_zero ? DONE : ITER;
      ITER:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = start ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy  = (state == SETUP) || (state == ITER) || (state == FIX);
    ready = (state == DONE);
  end

  // Iteration counter: loaded in SETUP, counts down through ITER
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              count <= '0;
    else if (state == SETUP)   count <= CNT_W'(WIDTH - 1);
    else if (state == ITER)    count <= count - CNT_W'(1);
  end

  // Architectural results and exception flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      rem       <= '0;
      exception <= 1'b0;
    end else begin
      if (accept) begin
        exception <= 1'b0;
      end else if (state == SETUP) begin
        if (b_zero) begin
          exception <= 1'b1;
          out       <= '0;
          rem       <= '0;
        end else if (ovf_case) begin
          exception <= 1'b1;
        end
      end else if (state == FIX) begin
        out <= cond_neg(q_reg, sign_a ^ sign_b);
        rem <= cond_neg(r_reg[WIDTH-1:0], sign_a);
      end
    end
  end

  // Operand latch and shift-subtract datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat <= data_A;
      b_lat <= data_B;
    end
    if (state == SETUP) begin
      sign_a <= a_lat[WIDTH-1];
      sign_b <= b_lat[WIDTH-1];
      q_reg  <= b_zero ? '0 : mag(a_lat);
      d_reg  <= mag(b_lat);
      r_reg  <= '0;
    end else if (state == ITER) begin
      q_reg <= {q_reg[WIDTH-2:0], trial_ok};
      r_reg <= trial_ok ? r_trial : rq_sh[WIDTH:0];
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider: signed results, exceptions, latency,
// ignored mid-operation starts, asynchronous reset and back-to-back accept.

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_A = '0;
  logic [31:0] data_B = '0;
  logic [31:0] out;
  logic [31:0] rem;
  logic        exception;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .data_A    (data_A),
    .data_B    (data_B),
    .out       (out),
    .rem       (rem),
    .exception (exception),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one rising edge (the accept edge E0).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    data_A = a;
    data_B = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the current point until ready is seen (0 = timeout).
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] exp_out,
                     input logic [31:0] exp_rem, input logic exp_exc);
    int n;
    issue(a, b);
    chk({tag, " busy_on"}, busy, 1);
    chk({tag, " exc_clr"}, exception, 0);
    wait_ready(n);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " out"}, out, exp_out);
    chk({tag, " rem"}, rem, exp_rem);
    chk({tag, " exc"}, exception, exp_exc);
    @(posedge clk);
    #1;
    chk({tag, " ready_width"}, ready, 0);
    chk({tag, " busy_off"}, busy, 0);
    chk({tag, " out_hold"}, out, exp_out);
    chk({tag, " exc_hold"}, exception, exp_exc);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst out", out, 0);
    chk("rst rem", rem, 0);
    chk("rst exc", exception, 0);
    chk("rst ready", ready, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic and sign handling
    run("100/7",   32'd100,       32'd7,         34, 32'd14,        32'd2,         1'b0);
    run("-100/7",  32'hFFFFFF9C,  32'd7,         34, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0);
    run("100/-7",  32'd100,       32'hFFFFFFF9,  34, 32'hFFFFFFF2,  32'd2,         1'b0);
    run("-100/-7", 32'hFFFFFF9C,  32'hFFFFFFF9,  34, 32'd14,        32'hFFFFFFFE,  1'b0);

    // Exceptions
    run("5/0",     32'd5,         32'd0,          1, 32'd0,         32'd0,         1'b1);
    run("min/-1",  32'h80000000,  32'hFFFFFFFF,  34, 32'h80000000,  32'd0,         1'b1);

    // Start pulse mid-operation is ignored; operand changes have no effect
    issue(32'd1000, 32'd10);
    chk("ign exc_clr", exception, 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    data_A = 32'd9;
    data_B = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data_A = 32'd55;
    chk("ign busy", busy, 1);
    wait_ready(lat);
    chk("ign latency", (lat == 0) ? 0 : lat + 10, 34);
    chk("ign out", out, 32'd100);
    chk("ign rem", rem, 32'd0);
    @(posedge clk);
    #1;
    chk("ign no_restart", busy, 0);

    // Asynchronous reset during an operation
    issue(32'd12345, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst out", out, 0);
    chk("arst rem", rem, 0);
    chk("arst exc", exception, 0);
    chk("arst ready", ready, 0);
    chk("arst busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run("-1/1", 32'hFFFFFFFF, 32'd1, 34, 32'hFFFFFFFF, 32'd0, 1'b0);

    // Back-to-back accept in the ready cycle
    issue(32'd7, 32'd2);
    wait_ready(lat);
    chk("b2b first latency", lat, 34);
    chk("b2b first out", out, 32'd3);
    chk("b2b first rem", rem, 32'd1);
    data_A = 32'h7FFFFFFF;
    data_B = 32'h00010000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b accepted", busy, 1);
    chk("b2b ready_low", ready, 0);
    wait_ready(lat);
    chk("b2b spacing", (lat == 0) ? 0 : lat + 1, 35);
    chk("b2b out", out, 32'h00007FFF);
    chk("b2b rem", rem, 32'h0000FFFF);
    chk("b2b exc", exception, 0);
    @(posedge clk);
    #1;
    chk("b2b ready_width", ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multicycle 32-bit signed integer divider that completes the processor's arithmetic path alongside the combinational `cl_adder`. It accepts a dividend/divisor pair on a one-cycle `start` pulse, runs a restoring shift-subtract loop (one quotient bit per cycle, trial subtraction done by an instantiated `cl_adder`) and returns quotient, remainder and an exception flag with a one-cycle `ready` pulse. The execute stage stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width. Only 32 is verified.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled on a rising `clk` edge.
- `data_A`  in  32  dividend, two's complement; latched on the accepted `start` edge.
- `data_B`  in  32  divisor, two's complement; latched on the same edge.
- `out`  out  32  quotient, truncated toward zero.
- `rem`  out  32  remainder; takes the sign of the dividend.
- `exception`  out  1  divide-by-zero or overflow (0x80000000 / -1); valid while `ready`=1.
- `ready`  out  1  one-cycle pulse: `out`, `rem` and `exception` are valid.
- `busy`  out  1  high from the accept edge until the edge that raises `ready`.

## Operation
- FSM states: IDLE, SETUP, ITER, FIX, DONE.
- **IDLE**
  - `start`=1 latches `data_A`/`data_B`; go to SETUP.
  - `start`=0: stay in IDLE.
- **SETUP**
  - Record the sign bits.
  - Form magnitudes: |A| into quotient register Q, |B| into divisor register D.
  - Clear partial remainder R (33 bits).
  - Load count=31.
  - If `data_B`==0: set `exception`, force Q=0 and R=0, go to DONE.
  - If A=0x80000000 and B=0xFFFFFFFF: set `exception`, continue normally.
  - Otherwise go to ITER.
- **ITER** (one step per cycle)
  - Shift {R,Q} left by 1.
  - Compute R−D through `cl_adder` (`data_A`=R[31:0], `data_B`=~D, `Cin`=1); its `overflow` output is unused.
  - Non-negative trial result: R takes the difference and Q[0]=1. Otherwise R is restored and Q[0]=0.
  - At count==0 go to FIX; otherwise decrement count.
- **FIX**
  - Negate Q when the sign bits differ.
  - Negate R when the dividend was negative.
  - Register the results into `out`/`rem`; go to DONE.
- **DONE**
  - `ready`=1 and `busy`=0 for exactly this cycle.
  - Next state is IDLE, or SETUP if `start`=1 (back-to-back accept).
- Width rules:
  - Magnitude of 0x80000000 is 2^31 and is held unsigned in 32 bits.
  - The overflow case yields `out`=0x80000000 and `rem`=0.
- `start` in SETUP, ITER or FIX is ignored. It is not queued.
- Changes to `data_A`/`data_B` after the accept edge have no effect.
- `out`/`rem` hold their last values until the next FIX or divide-by-zero SETUP, and remain readable after `ready` falls.
- `exception` holds until the next accept, which clears it.

## Timing
- Reset (`reset_n`=0, asynchronous, mid-operation included):
  - State goes to IDLE.
  - `out`, `rem`, `exception`, `ready`, `busy` = 0.
  - Any in-flight operation is discarded.
  - The first `start` after release is accepted normally.
- Normal operation, with E0 = accept edge:
  - E1 SETUP→ITER.
  - E2..E33: 32 iterations.
  - E34 FIX→DONE; `ready` is high in the cycle after E34. Latency is 34 cycles.
- Divide-by-zero: E1 SETUP→DONE; `ready` is high after E1. Latency is 1 cycle.
- `busy` rises on E0 and falls on the edge that raises `ready`.
- Throughput: one division per 35 cycles with back-to-back starts.
- `ready` never stays high for two consecutive cycles.

## Test plan
- 100 / 7:
  - `out`=14, `rem`=2, `exception`=0.
  - `ready` high exactly 34 cycles after accept, width 1 cycle.
- Sign handling:
  - −100 / 7 → `out`=0xFFFFFFF2, `rem`=0xFFFFFFFE.
  - 100 / −7 → `out`=0xFFFFFFF2, `rem`=2.
  - −100 / −7 → `out`=14, `rem`=0xFFFFFFFE.
- Exception cases:
  - 5 / 0 → `out`=0, `rem`=0, `exception`=1, `ready` 1 cycle after accept.
  - 0x80000000 / 0xFFFFFFFF → `out`=0x80000000, `rem`=0, `exception`=1, latency 34.
- Pulse `start` with 9/3 at cycle 10 after accepting 1000/10 → ignored; result is `out`=100, `rem`=0. Change `data_A` mid-operation → no effect.
- Assert `reset_n`=0 at cycle 15 of an operation:
  - All outputs drop to 0 immediately.
  - After release, 0xFFFFFFFF / 0x00000001 gives `out`=0xFFFFFFFF, `rem`=0.
- Back-to-back: `start` high in the `ready` cycle of 7/2 is accepted; second op 0x7FFFFFFF / 0x10000 gives `out`=0x7FFF, `rem`=0xFFFF, `ready` 35 cycles after the first.
